// File: rtl/mips_decls_p.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU operation selects and the bundled control word driven by mainfsm.
package mips_decls_p;

    // Instruction opcode field, instr[31:26]
    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    // Main controller states; 12 used codes, the remaining 4 fall to the default arm
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype_t;

    // ALU operation class handed to the ALU decoder (2'b11 is reserved)
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Datapath mux selects
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Everything the FSM drives into the datapath, as one word
    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // True for opcodes the controller knows how to sequence
    function automatic logic is_supported_op(input opcode_t op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: is_supported_op = 1'b1;
            default:                                       is_supported_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mainfsm.sv
// Multi-cycle MIPS main controller. Sequences fetch/decode/execute/memory/
// writeback and drives datapath enables, mux selects and the ALU op class.
// Outputs are decoded from the state register only; the single exception is
// badop, which also looks at the opcode, but that comes straight from the IR
// which is frozen after FETCH, so it is just as glitch-free as a state decode.
module mainfsm
    import mips_decls_p::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       badop
);

    statetype_t state_q, state_d;
    ctrl_t      ctrl;

    // State register; reset aborts any in-flight instruction back to FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state: opcode only matters in DECODE (dispatch) and MEMADR (LW vs SW)
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Output decode: start from all-zero so unlisted signals and stray codes stay quiet
    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.iord    = 1'b0;
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            DECODE: begin
                // Precompute the branch target while the register file is read
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.memtoreg = 1'b0;
                ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                // PC takes ALUOut (target from DECODE) only if the compare is zero
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b0;
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regwrite = ctrl.regwrite;
    assign pcwrite  = ctrl.pcwrite;
    assign branch   = ctrl.branch;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;

    // Unsupported opcode flag, visible for the single DECODE cycle
    assign badop = (state_q == DECODE) && !is_supported_op(opcode);

endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: an instruction-level model (cycle index within the
// instruction -> required control word) is compared every cycle, plus a few
// hand-computed control words pinned at specific cycles.
module tb_mainfsm;

    logic       clk, reset;
    logic [5:0] opcode;
    logic       memwrite, irwrite, regwrite, pcwrite, branch, iord, memtoreg, regdst, alusrca, badop;
    logic [1:0] alusrcb, pcsrc, aluop;

    int checks = 0;
    int errors = 0;

    mainfsm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .pcwrite(pcwrite),
        .branch(branch), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .badop(badop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed word: {memwrite,irwrite,regwrite,pcwrite,branch,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,aluop,badop}
    logic [15:0] obs;
    assign obs = {memwrite, irwrite, regwrite, pcwrite, branch, iord, memtoreg, regdst,
                  alusrca, alusrcb, pcsrc, aluop, badop};

    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'b100011: instr_len = 5;
            6'b101011, 6'b000000, 6'b001000: instr_len = 4;
            6'b000100, 6'b000010: instr_len = 3;
            default: instr_len = 2;
        endcase
    endfunction

    // Required control word for cycle ph (0 = fetch) of an instruction with opcode op
    function automatic logic [15:0] model_word(input logic [5:0] op, input int ph);
        logic mw, irw, rw, pcw, br, id, m2r, rd, sa, bad;
        logic [1:0] sb, ps, ao;
        {mw, irw, rw, pcw, br, id, m2r, rd, sa, bad} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        if (ph == 0) begin
            irw = 1; pcw = 1; sb = 2'b01;
        end else if (ph == 1) begin
            sb = 2'b11;
            bad = (instr_len(op) == 2);
        end else begin
            case (op)
                6'b100011: begin // LW: address, read, writeback
                    if (ph == 2) begin sa = 1; sb = 2'b10; end
                    else if (ph == 3) id = 1;
                    else begin rw = 1; m2r = 1; end
                end
                6'b101011: begin // SW: address, write
                    if (ph == 2) begin sa = 1; sb = 2'b10; end
                    else begin id = 1; mw = 1; end
                end
                6'b000000: begin // R-type: execute with funct, write rd
                    if (ph == 2) begin sa = 1; ao = 2'b10; end
                    else begin rw = 1; rd = 1; end
                end
                6'b001000: begin // ADDI: add immediate, write rt
                    if (ph == 2) begin sa = 1; sb = 2'b10; end
                    else rw = 1;
                end
                6'b000100: begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
                6'b000010: begin ps = 2'b10; pcw = 1; end
                default: ;
            endcase
        end
        model_word = {mw, irw, rw, pcw, br, id, m2r, rd, sa, sb, ps, ao, bad};
    endfunction

    // Model position: advances on every clock edge, restarts on reset
    int          m_phase = 0;
    logic [5:0]  m_op    = 6'b0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        logic [5:0] op_n;
        int         ph_n;
        if (reset) begin
            m_phase <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            op_n = (m_phase == 0) ? opcode : m_op;
            ph_n = m_phase + 1;
            if (ph_n >= instr_len(op_n)) ph_n = 0;
            m_op    <= op_n;
            m_phase <= ph_n;
        end
    end

    // Every-cycle compare against the model, plus invariants
    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (m_valid) begin
            exp_w = model_word(m_op, m_phase);
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL model phase=%0d op=%b: got %h expected %h", m_phase, m_op, obs, exp_w);
            end
            checks++;
            if ((memwrite && regwrite) || (pcwrite && branch) || aluop === 2'b11) begin
                errors++;
                $display("FAIL exclusivity: got mw=%b rw=%b pcw=%b br=%b aluop=%b", memwrite, regwrite, pcwrite, branch, aluop);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp_w);
        checks++;
        if (got !== exp_w) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp_w);
        end
    endtask

    logic [15:0] snap [0:7];

    // Start in FETCH (#1 after an edge); run n cycles, snapshotting each
    task automatic run_instr(input logic [5:0] op, input int n);
        opcode = op;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            snap[k] = obs;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 chk("reset_fetch", obs, 16'h5020);
        @(posedge clk);
        #1 reset = 1'b1;      // re-enter FETCH cleanly at an edge boundary
        @(posedge clk);
        #1 reset = 1'b0;

        // LW: 5 cycles, writeback only in cycle 5
        run_instr(6'b100011, 5);
        chk("lw_c1_fetch", snap[0], 16'h5020);
        chk("lw_c5_memwb", snap[4], 16'h2200);
        chk("lw_c4_memrd", snap[3], 16'h0400);

        // RTYPE: funct in cycle 3, rd writeback in cycle 4
        run_instr(6'b000000, 4);
        chk("rtype_c3_ex", snap[2], 16'h0084);
        chk("rtype_c4_wb", snap[3], 16'h2100);

        // BEQ then J
        run_instr(6'b000100, 3);
        chk("beq_c3_ex", snap[2], 16'h088A);
        run_instr(6'b000010, 3);
        chk("j_c3_jex", snap[2], 16'h1010);

        // Illegal opcodes: badop in DECODE only, 2 cycles
        run_instr(6'b111111, 2);
        chk("bad_c2_decode", snap[1], 16'h0061);
        chk("bad_c1_fetch", snap[0], 16'h5020);
        run_instr(6'b100000, 2);
        chk("bad2_c2_decode", snap[1], 16'h0061);

        // Plain SW
        run_instr(6'b101011, 4);
        chk("sw_c4_memwr", snap[3], 16'h8400);

        // SW aborted by reset during MEMADR
        opcode = 6'b101011;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("sw_abort_memadr", obs, 16'h00C0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("sw_abort_fetch", obs, 16'h5020);
        @(posedge clk);
        #1;
        // that edge moved to DECODE with SW; let it finish cleanly via reset
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // ADDI: 4 cycles, rt writeback in ADDIWB
        run_instr(6'b001000, 4);
        chk("addi_c3_ex", snap[2], 16'h00C0);
        chk("addi_c4_wb", snap[3], 16'h2000);
        run_instr(6'b100011, 5);
        chk("lw2_c5_memwb", snap[4], 16'h2200);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
